// File: rtl/decoder_pkg.sv
// Shared definitions for the one-hot strobe decoder and related blocks:
// the FSM state encoding, the hold/gap counter width and the binary to
// one-hot helper.
package decoder_pkg;

    localparam int CNT_W      = 8;
    localparam int MAX_CODE_W = 8;
    localparam int MAX_OUT_W  = 1 << MAX_CODE_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // One-hot of a binary code. The result is sized for the widest supported
    // code, so callers keep the low 2**CODE_W bits.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_CODE_W-1:0] code);
        logic [MAX_OUT_W-1:0] r;
        r       = '0;
        r[code] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/skid_buf1.sv
// Single-entry pending register with a valid/ready handshake on both sides.
// s_ready is high only while the entry is empty, so a push and a pop never
// occur in the same cycle.
module skid_buf1 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    logic         full_r;
    logic [W-1:0] data_r;

    assign s_ready = !full_r;
    assign m_valid = full_r;
    assign m_data  = data_r;

    // Capture a pushed entry; release it when the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_r <= 1'b0;
            data_r <= '0;
        end else if (s_valid && !full_r) begin
            full_r <= 1'b1;
            data_r <= s_data;
        end else if (m_ready && full_r) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

endmodule

// File: rtl/onehot_strobe_decoder.sv
// Sequential binary to one-hot strobe decoder. Each accepted code drives
// its one-hot line for HOLD enabled cycles, followed by GAP enabled idle
// cycles. One further code can wait in a single-entry pending buffer.
// en=0 blanks y and freezes the FSM and counters, but codes are still
// accepted into the pending buffer.
// Optional feature macro: ONEHOT_DEC_PARITY_EN adds the in_par input
// (even parity over in_code). A code with bad parity is accepted and then
// dropped, and err pulses for one cycle.
module onehot_strobe_decoder
    import decoder_pkg::*;
#(
    parameter int CODE_W = 3,
    parameter int HOLD   = 4,
    parameter int GAP    = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CODE_W-1:0]      in_code,
`ifdef ONEHOT_DEC_PARITY_EN
    input  logic                   in_par,
`endif
    input  logic                   en,
    output logic [2**CODE_W-1:0]   y,
    output logic                   y_valid,
    output logic                   busy,
    output logic                   err
);

    localparam int OUT_W = 2**CODE_W;
    localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_M1  = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

`ifdef ONEHOT_DEC_PARITY_EN
    // Even parity check: code and parity bit together must XOR to zero.
    function automatic logic parity_ok(input logic [CODE_W-1:0] code, input logic par);
        return ~(^{code, par});
    endfunction
`endif

    state_t                state_r, state_s;
    logic [CNT_W-1:0]      cnt_r, cnt_s;
    logic [CODE_W-1:0]     act_code_r, act_code_s;
    logic [OUT_W-1:0]      y_r, y_s;
    logic                  y_valid_r, y_valid_s;
    logic                  busy_r, busy_s;
    logic                  err_r, err_s;
    logic [MAX_OUT_W-1:0]  oh_full_s;

    logic                  xfer_s;
    logic                  par_ok_s;
    logic                  cnt_zero_s;
    logic                  boundary_s;
    logic                  direct_s;
    logic                  pop_s;
    logic                  has_next_s;
    logic [CODE_W-1:0]     next_code_s;
    logic                  buf_in_valid_s;
    logic                  pend_valid_s;
    logic [CODE_W-1:0]     pend_code_s;
    logic                  pend_next_s;

    // A parity-rejected code still completes the handshake but never reaches
    // the buffer. A code taken directly at a strobe boundary bypasses it.
    assign buf_in_valid_s = in_valid && par_ok_s && !direct_s;

    skid_buf1 #(
        .W (CODE_W)
    ) u_pend (
        .clk     (clk),
        .rst     (rst),
        .s_valid (buf_in_valid_s),
        .s_ready (in_ready),
        .s_data  (in_code),
        .m_valid (pend_valid_s),
        .m_ready (pop_s),
        .m_data  (pend_code_s)
    );

    // Handshake qualification and selection of the next code at a strobe boundary.
    always_comb begin
        xfer_s     = in_valid && in_ready;
`ifdef ONEHOT_DEC_PARITY_EN
        par_ok_s   = parity_ok(in_code, in_par);
`else
        par_ok_s   = 1'b1;
`endif
        cnt_zero_s = (cnt_r == '0);
        if (en) begin
            boundary_s = (state_r == ST_IDLE)
                      || ((state_r == ST_GAP) && cnt_zero_s)
                      || ((state_r == ST_DRIVE) && cnt_zero_s && (GAP == 0));
        end else begin
            boundary_s = 1'b0;
        end
        pop_s       = boundary_s && pend_valid_s;
        direct_s    = boundary_s && !pend_valid_s && xfer_s && par_ok_s;
        has_next_s  = pop_s || direct_s;
        if (pend_valid_s) begin
            next_code_s = pend_code_s;
        end else begin
            next_code_s = in_code;
        end
    end

    // Next state, hold/gap counter and active code. en=0 freezes all three.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        act_code_s = act_code_r;
        if (en) begin
            case (state_r)
                ST_IDLE: begin
                    if (has_next_s) begin
                        state_s    = ST_DRIVE;
                        cnt_s      = HOLD_M1;
                        act_code_s = next_code_s;
                    end else begin
                        state_s = ST_IDLE;
                        cnt_s   = '0;
                    end
                end
                ST_DRIVE: begin
                    if (!cnt_zero_s) begin
                        cnt_s = cnt_r - CNT_W'(1);
                    end else if (GAP > 0) begin
                        state_s = ST_GAP;
                        cnt_s   = GAP_M1;
                    end else if (has_next_s) begin
                        state_s    = ST_DRIVE;
                        cnt_s      = HOLD_M1;
                        act_code_s = next_code_s;
                    end else begin
                        state_s = ST_IDLE;
                        cnt_s   = '0;
                    end
                end
                ST_GAP: begin
                    if (!cnt_zero_s) begin
                        cnt_s = cnt_r - CNT_W'(1);
                    end else if (has_next_s) begin
                        state_s    = ST_DRIVE;
                        cnt_s      = HOLD_M1;
                        act_code_s = next_code_s;
                    end else begin
                        state_s = ST_IDLE;
                        cnt_s   = '0;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Output values for the next cycle: the strobe only in an enabled DRIVE
    // cycle, busy while a code is active or pending, err on a parity reject.
    always_comb begin
        oh_full_s = onehot(MAX_CODE_W'(act_code_s));
        if (en && (state_s == ST_DRIVE)) begin
            y_s = oh_full_s[OUT_W-1:0];
        end else begin
            y_s = '0;
        end
        y_valid_s   = |y_s;
        pend_next_s = (pend_valid_s && !pop_s) || (buf_in_valid_s && !pend_valid_s);
        busy_s      = (state_s != ST_IDLE) || pend_next_s;
        err_s       = xfer_s && !par_ok_s;
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            act_code_r <= '0;
            y_r        <= '0;
            y_valid_r  <= 1'b0;
            busy_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            act_code_r <= act_code_s;
            y_r        <= y_s;
            y_valid_r  <= y_valid_s;
            busy_r     <= busy_s;
            err_r      <= err_s;
        end
    end

    assign y       = y_r;
    assign y_valid = y_valid_r;
    assign busy    = busy_r;
    assign err     = err_r;

endmodule
